// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the M stage: accepts one load/store,
// stalls the pipeline while it is outstanding, and completes it in a single DONE cycle.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        MemStall,
  output logic        MemDone,
  output logic        AddrErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic [31:0]   acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic          acc_write_s;
  logic          complete_s;
  logic          valid_s;
  logic [AW-1:0] idx_s;
  logic          mem_we_s;

  // Next-state logic; with LATENCY==1 the access completes straight from IDLE,
  // so the completing access is taken from the inputs rather than the latches.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    acc_addr_s  = addr_q;
    acc_wdata_s = wdata_q;
    acc_write_s = write_q;
    complete_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemReq) begin
          addr_d      = ALUOutM;
          wdata_d     = WriteDataM;
          write_d     = MemWriteM;
          acc_addr_s  = ALUOutM;
          acc_wdata_s = WriteDataM;
          acc_write_s = MemWriteM;
          if (LATENCY == 1) begin
            state_d    = DONE;
            complete_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = DONE;
          complete_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_s  = (acc_addr_s[1:0] == 2'b00) && (acc_addr_s[31:AW+2] == '0);
    idx_s    = acc_addr_s[AW+1:2];
    mem_we_s = complete_s && valid_s && acc_write_s;

    if (complete_s) begin
      if (!valid_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      if (!acc_write_s) begin
        rdata_d = valid_s ? mem_q[idx_s] : 32'd0;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; reset clears every word, which also drops a pending store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_we_s) begin
      mem_q[idx_s] <= acc_wdata_s;
    end
  end

  assign MemStall = !reset && (((state_q == IDLE) && MemReq) || (state_q == WAIT));
  assign MemDone  = (state_q == DONE);
  assign ReadData = rdata_q;
  assign AddrErr  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 1, 2, 4) driven by
// directed and random accesses, checked against a word-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        done  [3];
  logic        aerr  [3];

  int          lat_a [3] = '{1, 2, 4};
  logic [31:0] mem_m [3][DEPTH];
  logic [31:0] rd_m  [3];
  logic        err_m [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut0 (
    .clk(clk), .reset(rst[0]), .MemReq(req[0]), .MemWriteM(we[0]), .ALUOutM(addr[0]),
    .WriteDataM(wdata[0]), .ReadData(rdata[0]), .MemStall(stall[0]), .MemDone(done[0]),
    .AddrErr(aerr[0]));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut1 (
    .clk(clk), .reset(rst[1]), .MemReq(req[1]), .MemWriteM(we[1]), .ALUOutM(addr[1]),
    .WriteDataM(wdata[1]), .ReadData(rdata[1]), .MemStall(stall[1]), .MemDone(done[1]),
    .AddrErr(aerr[1]));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) dut2 (
    .clk(clk), .reset(rst[2]), .MemReq(req[2]), .MemWriteM(we[2]), .ALUOutM(addr[2]),
    .WriteDataM(wdata[2]), .ReadData(rdata[2]), .MemStall(stall[2]), .MemDone(done[2]),
    .AddrErr(aerr[2]));

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    for (int k = 0; k < DEPTH; k++) mem_m[i][k] = 32'd0;
    rd_m[i]  = 32'd0;
    err_m[i] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with no request: responder must neither stall nor complete.
  task automatic idle(input int i, input int n);
    req[i] = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_stall", i, 32'(stall[i]), 32'd0);
      chk("idle_done", i, 32'(done[i]), 32'd0);
      next_cycle();
    end
  endtask

  // One access, request held through its DONE cycle; inputs scrambled after acceptance.
  task automatic do_access(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    int l;
    logic [31:0] rd_old;
    logic valid;
    l      = lat_a[i];
    rd_old = rd_m[i];
    valid  = (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
    if (w && valid) mem_m[i][a[7:2]] = d;
    if (!w) rd_m[i] = valid ? mem_m[i][a[7:2]] : 32'd0;
    if (!valid) err_m[i] = 1'b1;
    for (int c = 0; c <= l; c++) begin
      req[i] = 1'b1;
      if (c == 0) begin
        we[i] = w; addr[i] = a; wdata[i] = d;
      end else begin
        we[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
      end
      @(negedge clk);
      if (c < l) begin
        chk("stall_hi", i, 32'(stall[i]), 32'd1);
        chk("done_lo", i, 32'(done[i]), 32'd0);
        chk("rdata_hold", i, rdata[i], rd_old);
      end else begin
        chk("stall_lo", i, 32'(stall[i]), 32'd0);
        chk("done_hi", i, 32'(done[i]), 32'd1);
        chk("rdata", i, rdata[i], rd_m[i]);
        chk("addr_err", i, 32'(aerr[i]), 32'(err_m[i]));
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
      model_reset(i);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_stall", i, 32'(stall[i]), 32'd0);
      chk("rst_done", i, 32'(done[i]), 32'd0);
      chk("rst_rdata", i, rdata[i], 32'd0);
      chk("rst_err", i, 32'(aerr[i]), 32'd0);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // LATENCY=2: store then load in the next available cycle.
    do_access(1, 1'b1, 32'h10, 32'hDEADBEEF);
    do_access(1, 1'b0, 32'h10, 32'd0);
    chk("l2_load", 1, rd_m[1], 32'hDEADBEEF);
    idle(1, 1);

    // LATENCY=1: back-to-back stores, then loads.
    do_access(0, 1'b1, 32'h0, 32'h1);
    do_access(0, 1'b1, 32'h4, 32'h2);
    do_access(0, 1'b0, 32'h4, 32'd0);
    do_access(0, 1'b0, 32'h0, 32'd0);
    idle(0, 1);

    // Misaligned and out-of-range loads; memory must be untouched.
    do_access(1, 1'b0, 32'h12, 32'd0);
    do_access(1, 1'b0, 32'h100, 32'd0);
    do_access(1, 1'b0, 32'h10, 32'd0);
    idle(1, 1);

    // LATENCY=4: inputs change during WAIT, word 3 must stay clear.
    do_access(2, 1'b1, 32'h8, 32'hAA);
    do_access(2, 1'b0, 32'h8, 32'd0);
    do_access(2, 1'b0, 32'hC, 32'd0);
    idle(2, 1);

    // LATENCY=4: reset in the second WAIT cycle abandons the store.
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'h55;
    @(negedge clk);
    chk("rw_stall0", 2, 32'(stall[2]), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("rw_stall1", 2, 32'(stall[2]), 32'd1);
    next_cycle();
    rst[2] = 1'b1;
    @(negedge clk);
    chk("rw_stall_rst", 2, 32'(stall[2]), 32'd0);
    next_cycle();
    rst[2] = 1'b0;
    req[2] = 1'b0;
    model_reset(2);
    @(negedge clk);
    chk("rw_stall_after", 2, 32'(stall[2]), 32'd0);
    chk("rw_done_after", 2, 32'(done[2]), 32'd0);
    chk("rw_rdata_after", 2, rdata[2], 32'd0);
    chk("rw_err_after", 2, 32'(aerr[2]), 32'd0);
    next_cycle();
    do_access(2, 1'b0, 32'h8, 32'd0);
    idle(2, 1);

    // Reset with MemReq held: no stall during reset, accept right after.
    rst[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rh_stall", 1, 32'(stall[1]), 32'd0);
      chk("rh_done", 1, 32'(done[1]), 32'd0);
      next_cycle();
    end
    rst[1] = 1'b0;
    model_reset(1);
    do_access(1, 1'b0, 32'h10, 32'd0);
    idle(1, 1);

    // Random traffic on every instance, including back-to-back requests.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 25; n++) begin
        int r;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1) a = 32'($urandom_range(256, 65535)) & 32'hFFFF_FFFC;
        else             a = 32'($urandom_range(0, 7)) << 2;
        do_access(i, 1'($urandom), a, $urandom);
        idle(i, int'($urandom_range(0, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
